// File: rtl/ctrl_filtro_20_pkg.sv
// Shared types and constants for the 20-kHz biquad sequencer.
// State encoding, operand selects and fixed latency.
package filtro_pkg;

   localparam int SEL_W = 4;
   localparam int CTRL_LATENCY = 12;

   localparam logic [SEL_W-1:0] SEL_U    = 4'd0;
   localparam logic [SEL_W-1:0] SEL_A1   = 4'd1;
   localparam logic [SEL_W-1:0] SEL_A2   = 4'd2;
   localparam logic [SEL_W-1:0] SEL_B0   = 4'd3;
   localparam logic [SEL_W-1:0] SEL_B1   = 4'd4;
   localparam logic [SEL_W-1:0] SEL_B2   = 4'd5;
   localparam logic [SEL_W-1:0] SEL_IDLE = 4'hF;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      CLR1 = 4'd1,
      MAC0 = 4'd2,
      MAC1 = 4'd3,
      MAC2 = 4'd4,
      STF  = 4'd5,
      CLR2 = 4'd6,
      MAC3 = 4'd7,
      MAC4 = 4'd8,
      MAC5 = 4'd9,
      LDY  = 4'd10,
      SHF  = 4'd11,
      FIN  = 4'd12
   } state_t;

   // Non-MAC states park the coefficient mux on its zero input.
   function automatic logic [SEL_W-1:0] sel_of(state_t s);
      logic [SEL_W-1:0] v;
      v = SEL_IDLE;
      unique case (s)
         MAC0:    v = SEL_U;
         MAC1:    v = SEL_A1;
         MAC2:    v = SEL_A2;
         MAC3:    v = SEL_B0;
         MAC4:    v = SEL_B1;
         MAC5:    v = SEL_B2;
         default: v = SEL_IDLE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ctrl_filtro_20_if.sv
// Control bundle between the biquad sequencer and its neighbours.
// The sequencer takes the slave side.
interface ctrl_filtro_20_if #(
   parameter int CNT_W = 16
);
   import filtro_pkg::*;

   logic             en;
   logic             start;
   logic [SEL_W-1:0] sel;
   logic             rst_acum;
   logic             leer;
   logic             desp;
   logic             leer_y;
   logic             busy;
   logic             done;
   logic             overrun;
   logic [CNT_W-1:0] n_muestras;

   modport master (
      output en, start,
      input  sel, rst_acum, leer, desp, leer_y,
      input  busy, done, overrun, n_muestras
   );

   modport slave (
      input  en, start,
      output sel, rst_acum, leer, desp, leer_y,
      output busy, done, overrun, n_muestras
   );

endinterface

// File: rtl/ctrl_filtro_20.sv
// Sequencing FSM for the Direct Form II biquad datapath.
// Moore outputs decoded from the registered state.
module ctrl_filtro_20
   import filtro_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   ctrl_filtro_20_if.slave bus
);

   state_t state;
   state_t state_n;
   logic   active;

   assign active = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bus.start && bus.en) state_n = CLR1;
         CLR1:    state_n = MAC0;
         MAC0:    state_n = MAC1;
         MAC1:    state_n = MAC2;
         MAC2:    state_n = STF;
         STF:     state_n = CLR2;
         CLR2:    state_n = MAC3;
         MAC3:    state_n = MAC4;
         MAC4:    state_n = MAC5;
         MAC5:    state_n = LDY;
         LDY:     state_n = SHF;
         SHF:     state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.sel      = sel_of(state);
      bus.rst_acum = 1'b0;
      bus.leer     = 1'b0;
      bus.desp     = 1'b0;
      bus.leer_y   = 1'b0;
      bus.done     = 1'b0;
      bus.busy     = active;
      unique case (1'b1)
         (state == CLR1),
         (state == CLR2): bus.rst_acum = 1'b1;
         (state == STF):  bus.leer     = 1'b1;
         (state == LDY):  bus.leer_y   = 1'b1;
         (state == SHF):  bus.desp     = 1'b1;
         (state == FIN):  bus.done     = 1'b1;
         default: ;
      endcase
   end

   // A start seen in any non-IDLE state, FIN included, is an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.overrun    <= 1'b0;
         bus.n_muestras <= '0;
      end else begin
         if (bus.start && active) bus.overrun <= 1'b1;
         if (state == FIN) bus.n_muestras <= bus.n_muestras + 1'b1;
      end
   end

endmodule

// File: doc/ctrl_filtro_20.md
Name: ctrl_filtro_20

Overview:
- Sequencing FSM for the 20-kHz IIR biquad datapath (coefficient mux, state memory, MAC, accumulator, rounding, Y register).
- Sits directly upstream of the datapath and drives its control inputs sel, leer, desp, leer_y and rst_acum.
- On each sample strobe it runs the Direct Form II recursion: first f = u·k0 + f1·k1 + f2·k2, then y = f·k3 + f1·k4 + f2·k5.
- It then latches y, shifts the state memory and reports completion.

Parameters:
- SEL_W, 4, width of the coefficient/operand select bus.
- SEL_IDLE, 4'hF, sel value driven whenever no MAC step is active (coefficient mux returns 0).
- CNT_W, 16, width of the processed-sample counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  enable; start is ignored while low.
- start  in  1  one-cycle pulse: new sample uu is valid and held stable until done.
- sel  out  SEL_W  operand/coefficient select to the datapath.
- rst_acum  out  1  clears the datapath accumulator.
- leer  out  1  writes the rounded f into state memory.
- desp  out  1  shifts state memory (f2<=f1, f1<=f).
- leer_y  out  1  loads the rounded y into the output register.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse: y is valid.
- overrun  out  1  sticky; set when start arrives while busy. Cleared only by rst.
- n_muestras  out  CNT_W  count of completed samples; wraps to 0.

Behaviour:
- Reset values: state IDLE, sel=SEL_IDLE, all strobes 0, busy=0, done=0, overrun=0, n_muestras=0.
- Outputs are Moore-decoded from the registered state, so a strobe is active during the cycle the FSM is in the corresponding state.
- States and outputs:
  - IDLE: busy=0.
  - CLR1: rst_acum=1.
  - MAC0: sel=0.
  - MAC1: sel=1.
  - MAC2: sel=2.
  - STF: leer=1.
  - CLR2: rst_acum=1.
  - MAC3: sel=3.
  - MAC4: sel=4.
  - MAC5: sel=5.
  - LDY: leer_y=1.
  - SHF: desp=1.
  - FIN: done=1.
- Transitions:
  - IDLE -> CLR1 when start & en; otherwise stay in IDLE.
  - Every other state advances unconditionally in the listed order.
  - FIN -> IDLE.
- Timing: if start is sampled at edge 0, the FSM is in CLR1 in cycle 1, MAC0 in cycle 2, ..., SHF in cycle 11, FIN in cycle 12. Fixed latency is 12 cycles; minimum start spacing is 13 cycles.
- In every non-MAC state, sel=SEL_IDLE.
- At most one of leer, desp, leer_y and rst_acum is high in any cycle.
- The accumulator is one cycle deep, so STF and LDY each follow their last MAC state directly with no wait state.
- n_muestras increments by 1 on the FIN cycle and wraps modulo 2^CNT_W.
- start while busy (CLR1..FIN): the pulse is dropped and overrun is set on the next edge. The running sequence is not disturbed.
- start in the same cycle as FIN: treated as busy, so it is dropped and overrun is set.
- en low while busy: no effect; the current sequence completes.
- rst mid-sequence: next edge forces IDLE and all reset values. No partial leer/desp is issued after the reset edge.
- rst and start in the same cycle: rst wins; the FSM stays in IDLE.

Decomposition:
- Shared package filtro_pkg holds:
  - the state enumeration (4-bit encoding);
  - SEL constants SEL_U=0 .. SEL_B2=5;
  - SEL_IDLE;
  - CTRL_LATENCY=12.
- No sub-module. The counter and overrun flag are simple registers inside the FSM module.

Test Plan:
- Reset then single sample: rst 2 cycles, start at t0 -> rst_acum at t1 and t6; sel 0,1,2 at t2-t4; leer at t5; sel 3,4,5 at t7-t9; leer_y at t10; desp at t11; done at t12; n_muestras=1.
- Back-to-back: start every 13 cycles for 5 samples -> 5 done pulses, overrun=0, n_muestras=5.
- Overrun: start at t0 and again at t4 -> one done at t12, overrun=1 from t5 onward, n_muestras=1. A start coincident with FIN also sets overrun.
- Enable gating: en=0 with a start pulse -> stays IDLE, no strobes, sel=4'hF. en dropped at t3 of a sequence -> sequence still completes at t12.
- Reset mid-run: rst at t7 -> at t8 state IDLE, sel=4'hF, no leer_y/desp afterwards, busy=0, n_muestras unchanged (0).
- Wrap and exclusivity: preload via 65536 samples (CNT_W=16) -> n_muestras returns to 0. Assertion on every cycle: one-hot-or-zero across {leer, desp, leer_y, rst_acum}.
